// File: rtl/commit_retire_serializer.sv
// Circular buffer that captures up to three retiring instructions per cycle and
// replays them oldest-first on a ready/valid stream, with halt drain tracking.
module commit_retire_serializer #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        commit_valid,
    input  logic [2:0]        commit_wr_en,
    input  logic [14:0]       commit_wr_idx,
    input  logic [3*XLEN-1:0] commit_wr_data,
    input  logic [3*XLEN-1:0] commit_NPC,
    input  logic              halt_commit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wr_en,
    output logic [4:0]        out_wr_idx,
    output logic [XLEN-1:0]   out_wr_data,
    output logic [XLEN-1:0]   out_NPC,
    output logic              almost_full,
    output logic              overflow,
    output logic              drained,
    output logic [31:0]       retired_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     retired_q, retired_d;

    logic            wr_en_mem [DEPTH];
    logic [4:0]      idx_mem   [DEPTH];
    logic [XLEN-1:0] data_mem  [DEPTH];
    logic [XLEN-1:0] npc_mem   [DEPTH];

    logic [CW-1:0]   free_s;
    logic [CW-1:0]   enq_n_s;
    logic            drop_s;
    logic            deq_s;
    logic            lane_acc_s  [3];
    logic [PW-1:0]   lane_slot_s [3];

    // Lane compaction: qualifying lanes take consecutive slots until free space runs out.
    always_comb begin
        free_s  = CW'(DEPTH) - count_q;
        enq_n_s = '0;
        drop_s  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lane_acc_s[i]  = 1'b0;
            lane_slot_s[i] = tail_q + enq_n_s[PW-1:0];
            if ((state_q == ST_RUN) && commit_valid[i]) begin
                if (enq_n_s < free_s) begin
                    lane_acc_s[i] = 1'b1;
                    enq_n_s       = enq_n_s + CW'(1);
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                lane_acc_s[i] = 1'b0;
            end
        end
    end

    // Pointer, counter and halt state machine next-state logic.
    always_comb begin
        deq_s      = out_valid && out_ready;
        head_d     = head_q + {{(PW-1){1'b0}}, deq_s};
        tail_d     = tail_q + enq_n_s[PW-1:0];
        count_d    = count_q + enq_n_s - {{(CW-1){1'b0}}, deq_s};
        overflow_d = overflow_q | drop_s;
        retired_d  = retired_q + {31'd0, deq_s};
        state_d    = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_commit) begin
                    // An empty buffer at halt finishes without a DRAIN cycle.
                    state_d = (count_d == '0) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            retired_q  <= retired_d;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (lane_acc_s[i]) begin
                wr_en_mem[lane_slot_s[i]] <= commit_wr_en[i];
                idx_mem[lane_slot_s[i]]   <= commit_wr_idx[5*i +: 5];
                data_mem[lane_slot_s[i]]  <= commit_wr_data[XLEN*i +: XLEN];
                npc_mem[lane_slot_s[i]]   <= commit_NPC[XLEN*i +: XLEN];
            end
        end
    end

    assign out_valid     = (count_q != '0) && (state_q != ST_DONE);
    assign out_wr_en     = wr_en_mem[head_q];
    assign out_wr_idx    = idx_mem[head_q];
    assign out_wr_data   = data_mem[head_q];
    assign out_NPC       = npc_mem[head_q];
    assign almost_full   = (count_q >= CW'(DEPTH - 3));
    assign overflow      = overflow_q;
    assign drained       = (state_q == ST_DONE);
    assign retired_count = retired_q;

endmodule

// File: tb/tb_commit_retire_serializer.sv
// Directed bench for commit_retire_serializer: a vector table for basic
// retirement plus hand-written overflow, wrap, halt and reset sequences.
module tb_commit_retire_serializer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic              clock;
    logic              reset;
    logic [2:0]        commit_valid;
    logic [2:0]        commit_wr_en;
    logic [14:0]       commit_wr_idx;
    logic [3*XLEN-1:0] commit_wr_data;
    logic [3*XLEN-1:0] commit_NPC;
    logic              halt_commit;
    logic              out_valid;
    logic              out_ready;
    logic              out_wr_en;
    logic [4:0]        out_wr_idx;
    logic [XLEN-1:0]   out_wr_data;
    logic [XLEN-1:0]   out_NPC;
    logic              almost_full;
    logic              overflow;
    logic              drained;
    logic [31:0]       retired_count;

    int checks = 0;
    int errors = 0;

    commit_retire_serializer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_wr_en(commit_wr_en),
        .commit_wr_idx(commit_wr_idx), .commit_wr_data(commit_wr_data),
        .commit_NPC(commit_NPC), .halt_commit(halt_commit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wr_en(out_wr_en), .out_wr_idx(out_wr_idx),
        .out_wr_data(out_wr_data), .out_NPC(out_NPC),
        .almost_full(almost_full), .overflow(overflow),
        .drained(drained), .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  cv;
        logic [2:0]  we;
        logic [14:0] idx;
        logic [95:0] data;
        logic [95:0] npc;
        logic        rdy;
        logic        vld;
        logic        ewe;
        logic [4:0]  eidx;
        logic [31:0] edata;
        logic [31:0] enpc;
        logic [31:0] erc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lanes(input logic [2:0] cv, input logic [31:0] n0, input logic [31:0] n1,
                         input logic [31:0] n2);
        commit_valid   = cv;
        commit_wr_en   = cv;
        commit_wr_idx  = {n2[4:0], n1[4:0], n0[4:0]};
        commit_wr_data = {n2, n1, n0};
        commit_NPC     = {n2, n1, n0};
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        halt_commit = 1'b0;
        out_ready   = 1'b0;
        lanes(3'b000, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1},
                    {32'hC, 32'h8, 32'h4}, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1, 32'h4, 32'd0};
        vecs[1] = '{3'b000, 3'b000, 15'd0, 96'd0, 96'd0, 1'b1,
                    1'b1, 1'b1, 5'd2, 32'h2, 32'h8, 32'd1};
        vecs[2] = '{3'b000, 3'b000, 15'd0, 96'd0, 96'd0, 1'b1,
                    1'b1, 1'b1, 5'd3, 32'h3, 32'hC, 32'd2};
        vecs[3] = '{3'b000, 3'b000, 15'd0, 96'd0, 96'd0, 1'b1,
                    1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd3};
        vecs[4] = '{3'b101, 3'b001, {5'd7, 5'd9, 5'd5}, {32'hBB, 32'hDEAD, 32'hAA},
                    {32'h18, 32'h14, 32'h10}, 1'b0, 1'b1, 1'b1, 5'd5, 32'hAA, 32'h10, 32'd3};
        vecs[5] = '{3'b000, 3'b000, 15'd0, 96'd0, 96'd0, 1'b1,
                    1'b1, 1'b0, 5'd7, 32'hBB, 32'h18, 32'd4};
        vecs[6] = '{3'b000, 3'b000, 15'd0, 96'd0, 96'd0, 1'b1,
                    1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd5};
        vecs[7] = '{3'b000, 3'b000, 15'd0, 96'd0, 96'd0, 1'b0,
                    1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd5};

        // Reset values while reset is held
        reset = 1'b0;
        halt_commit = 1'b0;
        out_ready = 1'b0;
        lanes(3'b000, 32'd0, 32'd0, 32'd0);
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rc", 64'(retired_count), 64'd0);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drained", 64'(drained), 64'd0);
        do_reset();

        // Table-driven basic retirement and compaction
        for (int v = 0; v < 8; v++) begin
            commit_valid   = vecs[v].cv;
            commit_wr_en   = vecs[v].we;
            commit_wr_idx  = vecs[v].idx;
            commit_wr_data = vecs[v].data;
            commit_NPC     = vecs[v].npc;
            out_ready      = vecs[v].rdy;
            tick();
            chk($sformatf("tbl%0d_valid", v), 64'(out_valid), 64'(vecs[v].vld));
            chk($sformatf("tbl%0d_rc", v), 64'(retired_count), 64'(vecs[v].erc));
            chk($sformatf("tbl%0d_ovf", v), 64'(overflow), 64'd0);
            if (vecs[v].vld) begin
                chk($sformatf("tbl%0d_we", v), 64'(out_wr_en), 64'(vecs[v].ewe));
                chk($sformatf("tbl%0d_idx", v), 64'(out_wr_idx), 64'(vecs[v].eidx));
                chk($sformatf("tbl%0d_data", v), 64'(out_wr_data), 64'(vecs[v].edata));
                chk($sformatf("tbl%0d_npc", v), 64'(out_NPC), 64'(vecs[v].enpc));
            end
        end

        // Fill to overflow, then drain 16 entries in order
        do_reset();
        for (int k = 0; k < 6; k++) begin
            lanes(3'b111, 32'(3*k), 32'(3*k+1), 32'(3*k+2));
            tick();
            chk($sformatf("fill%0d_af", k), 64'(almost_full), (k >= 4) ? 64'd1 : 64'd0);
            chk($sformatf("fill%0d_ovf", k), 64'(overflow), (k == 5) ? 64'd1 : 64'd0);
        end
        lanes(3'b000, 32'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_out%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("ovf_out%0d_npc", i), 64'(out_NPC), 64'(i));
            tick();
        end
        chk("ovf_empty_valid", 64'(out_valid), 64'd0);
        chk("ovf_rc", 64'(retired_count), 64'd16);

        // Full-rate single-lane stream wrapping the pointers three times
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3*DEPTH; i++) begin
            lanes(3'b001, 32'h1000 + 32'(4*i), 32'd0, 32'd0);
            tick();
            chk($sformatf("wrap%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("wrap%0d_npc", i), 64'(out_NPC), 64'(32'h1000 + 32'(4*i)));
        end
        lanes(3'b000, 32'd0, 32'd0, 32'd0);
        tick();
        chk("wrap_end_valid", 64'(out_valid), 64'd0);
        chk("wrap_rc", 64'(retired_count), 64'(3*DEPTH));
        chk("wrap_ovf", 64'(overflow), 64'd0);

        // Halt with 4 buffered plus 2 lanes in the halt cycle
        do_reset();
        lanes(3'b111, 32'd0, 32'd1, 32'd2);
        tick();
        lanes(3'b001, 32'd3, 32'd0, 32'd0);
        tick();
        halt_commit = 1'b1;
        lanes(3'b011, 32'd4, 32'd5, 32'h77);
        tick();
        lanes(3'b111, 32'h99, 32'h99, 32'h99);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("halt_out%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("halt_out%0d_npc", i), 64'(out_NPC), 64'(i));
            chk($sformatf("halt_out%0d_drained", i), 64'(drained), 64'd0);
            tick();
        end
        chk("halt_done_drained", 64'(drained), 64'd1);
        chk("halt_done_valid", 64'(out_valid), 64'd0);
        repeat (3) tick();
        chk("halt_late_valid", 64'(out_valid), 64'd0);
        chk("halt_late_drained", 64'(drained), 64'd1);
        chk("halt_late_rc", 64'(retired_count), 64'd6);

        // Halt with an empty buffer completes right after the halt edge
        do_reset();
        chk("ehalt_pre_drained", 64'(drained), 64'd0);
        halt_commit = 1'b1;
        tick();
        halt_commit = 1'b0;
        chk("ehalt_drained", 64'(drained), 64'd1);

        // Asynchronous reset mid-stream with 5 entries buffered
        do_reset();
        for (int k = 0; k < 6; k++) begin
            lanes(3'b111, 32'(k), 32'(k), 32'(k));
            tick();
        end
        lanes(3'b000, 32'd0, 32'd0, 32'd0);
        out_ready = 1'b1;
        repeat (11) tick();
        out_ready = 1'b0;
        chk("mid_pre_rc", 64'(retired_count), 64'd11);
        chk("mid_pre_ovf", 64'(overflow), 64'd1);
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_rc", 64'(retired_count), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_af", 64'(almost_full), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
